// File: rtl/vga_bounce_pic_gen.sv
// vga_bounce_pic_gen
// Pixel source for the VGA timing controller. Eight vertical colour bars form
// the background and a solid square is drawn over them. The square moves once
// per frame during blanking, bounces off the screen edges and takes a new
// colour on every bounce. pic_data is returned one cycle after the request.
module vga_bounce_pic_gen (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic [9:0]  pic_x,
  input  logic [9:0]  pic_y,
  input  logic        pause,
  output logic [15:0] pic_data,
  output logic [2:0]  bounce_cnt,
  output logic        frame_tick
);

  // Geometry is held at 11 bits so the edge sums below cannot wrap.
  localparam logic [10:0] H_VALID  = 11'd640;
  localparam logic [10:0] V_VALID  = 11'd480;
  localparam logic [10:0] BAR_W    = 11'd80;
  localparam logic [10:0] BOX_SIZE = 11'd64;
  localparam logic [10:0] STEP     = 11'd2;
  localparam logic [9:0]  START_X  = 10'd0;
  localparam logic [9:0]  START_Y  = 10'd0;
  localparam logic [10:0] X_LIMIT  = H_VALID - BOX_SIZE;
  localparam logic [10:0] Y_LIMIT  = V_VALID - BOX_SIZE;
  localparam logic [10:0] X_LAST   = H_VALID - 11'd1;
  localparam logic [10:0] Y_LAST   = V_VALID - 11'd1;

  // Background bar colours, left to right.
  function automatic logic [15:0] bar_pal(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_pal = 16'hFFFF;
      3'd1:    bar_pal = 16'hFFE0;
      3'd2:    bar_pal = 16'h07FF;
      3'd3:    bar_pal = 16'h07E0;
      3'd4:    bar_pal = 16'hF81F;
      3'd5:    bar_pal = 16'hF800;
      3'd6:    bar_pal = 16'h001F;
      3'd7:    bar_pal = 16'h0000;
      default: bar_pal = 16'h0000;
    endcase
  endfunction

  // Square colours, selected by the bounce count.
  function automatic logic [15:0] box_pal(input logic [2:0] idx);
    case (idx)
      3'd0:    box_pal = 16'hFD20;
      3'd1:    box_pal = 16'h8010;
      3'd2:    box_pal = 16'h0410;
      3'd3:    box_pal = 16'h7BEF;
      3'd4:    box_pal = 16'hF810;
      3'd5:    box_pal = 16'h041F;
      3'd6:    box_pal = 16'hFC10;
      3'd7:    box_pal = 16'h2104;
      default: box_pal = 16'h0000;
    endcase
  endfunction

  logic [9:0]  r_box_x;
  logic [9:0]  r_box_y;
  logic        r_dir_x;      // 1 = moving right
  logic        r_dir_y;      // 1 = moving down
  logic [2:0]  r_bounce_cnt;
  logic [15:0] r_pic_data;
  logic        r_frame_tick;

  logic [10:0] w_px;
  logic [10:0] w_py;
  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic        w_valid;
  logic        w_in_box;
  logic [2:0]  w_bar_idx;
  logic [15:0] w_pix_next;
  logic [9:0]  w_nx;
  logic [9:0]  w_ny;
  logic        w_ndx;
  logic        w_ndy;
  logic        w_hit_x;
  logic        w_hit_y;
  logic [2:0]  w_cnt_next;

  assign w_px = {1'b0, pic_x};
  assign w_py = {1'b0, pic_y};
  assign w_bx = {1'b0, r_box_x};
  assign w_by = {1'b0, r_box_y};

  // Pixel colour for the current request: blank, square, or background bar.
  always_comb begin
    w_pix_next = 16'h0000;
    w_valid    = (w_px < H_VALID) && (w_py < V_VALID);
    w_in_box   = (w_px >= w_bx) && (w_px < (w_bx + BOX_SIZE)) &&
                 (w_py >= w_by) && (w_py < (w_by + BOX_SIZE));
    if (w_px < BAR_W) begin
      w_bar_idx = 3'd0;
    end else if (w_px < (BAR_W * 11'd2)) begin
      w_bar_idx = 3'd1;
    end else if (w_px < (BAR_W * 11'd3)) begin
      w_bar_idx = 3'd2;
    end else if (w_px < (BAR_W * 11'd4)) begin
      w_bar_idx = 3'd3;
    end else if (w_px < (BAR_W * 11'd5)) begin
      w_bar_idx = 3'd4;
    end else if (w_px < (BAR_W * 11'd6)) begin
      w_bar_idx = 3'd5;
    end else if (w_px < (BAR_W * 11'd7)) begin
      w_bar_idx = 3'd6;
    end else begin
      w_bar_idx = 3'd7;
    end
    if (!w_valid) begin
      w_pix_next = 16'h0000;
    end else if (w_in_box) begin
      w_pix_next = box_pal(r_bounce_cnt);
    end else begin
      w_pix_next = bar_pal(w_bar_idx);
    end
  end

  // Next square position/direction; each axis clamps to its edge and reverses.
  always_comb begin
    w_nx    = r_box_x;
    w_ny    = r_box_y;
    w_ndx   = r_dir_x;
    w_ndy   = r_dir_y;
    w_hit_x = 1'b0;
    w_hit_y = 1'b0;
    if (r_dir_x) begin
      if ((w_bx + BOX_SIZE + STEP) > H_VALID) begin
        w_nx    = X_LIMIT[9:0];
        w_ndx   = 1'b0;
        w_hit_x = 1'b1;
      end else begin
        w_nx = r_box_x + STEP[9:0];
      end
    end else begin
      if (w_bx < STEP) begin
        w_nx    = 10'd0;
        w_ndx   = 1'b1;
        w_hit_x = 1'b1;
      end else begin
        w_nx = r_box_x - STEP[9:0];
      end
    end
    if (r_dir_y) begin
      if ((w_by + BOX_SIZE + STEP) > V_VALID) begin
        w_ny    = Y_LIMIT[9:0];
        w_ndy   = 1'b0;
        w_hit_y = 1'b1;
      end else begin
        w_ny = r_box_y + STEP[9:0];
      end
    end else begin
      if (w_by < STEP) begin
        w_ny    = 10'd0;
        w_ndy   = 1'b1;
        w_hit_y = 1'b1;
      end else begin
        w_ny = r_box_y - STEP[9:0];
      end
    end
    // A corner hit counts as a single bounce.
    if (w_hit_x || w_hit_y) begin
      w_cnt_next = r_bounce_cnt + 3'd1;
    end else begin
      w_cnt_next = r_bounce_cnt;
    end
  end

  // Registered pixel output and end-of-frame pulse.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pic_data   <= 16'h0000;
      r_frame_tick <= 1'b0;
    end else begin
      r_pic_data   <= w_pix_next;
      r_frame_tick <= (w_px == X_LAST) && (w_py == Y_LAST);
    end
  end

  // Square motion: once per frame, in blanking, unless paused.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_box_x      <= START_X;
      r_box_y      <= START_Y;
      r_dir_x      <= 1'b1;
      r_dir_y      <= 1'b1;
      r_bounce_cnt <= 3'd0;
    end else if (r_frame_tick && !pause) begin
      r_box_x      <= w_nx;
      r_box_y      <= w_ny;
      r_dir_x      <= w_ndx;
      r_dir_y      <= w_ndy;
      r_bounce_cnt <= w_cnt_next;
    end
  end

  assign pic_data   = r_pic_data;
  assign bounce_cnt = r_bounce_cnt;
  assign frame_tick = r_frame_tick;

endmodule
